// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - serialise a WIDTH-bit word into bytes for a uart transmit core
//
// Purpose: accepts one word from a valid/ready producer and sends it as WIDTH/8
// consecutive bytes. Each byte is started with a one-cycle transmit pulse to the
// uart core. The block then follows the core's is_transmitting flag to pace the
// bytes.
//
// Ports:
//   clk, rst          clock (shared with the uart core), synchronous active-high reset
//   in_valid/in_ready word handshake; in_word is sampled on the accept cycle only
//   transmit, tx_byte start pulse and byte to the uart core
//   is_transmitting   uart core busy flag
//   busy              high from the cycle after accept until done
//   done              one-cycle pulse after the last byte's stop bit
module uart_word_tx #(
  parameter int WIDTH     = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             transmit,
  output logic [7:0]       tx_byte,
  input  logic             is_transmitting,
  output logic             busy,
  output logic             done
);

  localparam int NBYTES = WIDTH / 8;
  // One spare bit so the count can hold NBYTES itself for every legal WIDTH.
  localparam int CW     = $clog2(NBYTES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PULSE,
    WAIT_START,
    WAIT_DONE,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             transmit_q, transmit_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0]       cur_byte;
  logic [CW-1:0]    count_dec;

  // The byte to send always sits at the send-side end of the shift register.
  assign cur_byte  = MSB_FIRST ? shreg_q[WIDTH-1 -: 8] : shreg_q[7:0];
  assign count_dec = count_q - CW'(1);

  assign in_ready = (state_q == IDLE) && !rst;
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    count_d    = count_q;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    transmit_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          shreg_d = in_word;
          count_d = CW'(NBYTES);
          busy_d  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        // tx_byte is loaded here so it is already stable when transmit rises.
        tx_byte_d = cur_byte;
        if (!is_transmitting) begin
          transmit_d = 1'b1;
          state_d    = PULSE;
        end
      end
      PULSE: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (is_transmitting) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
          count_d = count_dec;
          if (count_dec == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            state_d = ARM;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      count_q    <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      count_q    <= count_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - randomized self-checking bench for uart_word_tx
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_word = '0;
  logic        force_busy = 1'b0;
  int          uart_cnt = 0;
  logic        is_tx;

  logic        in_ready_m, transmit_m, busy_m, done_m;
  logic [7:0]  tx_byte_m;
  logic        in_ready_l, transmit_l, busy_l, done_l;
  logic [7:0]  tx_byte_l;

  logic        valid_b = 1'b0;
  logic [7:0]  word_b = '0;
  int          uart_cnt_b = 0;
  logic        is_tx_b;
  logic        in_ready_b, transmit_b, busy_b, done_b;
  logic [7:0]  tx_byte_b;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  int done_cnt  = 0;
  logic [7:0] qm[$];
  logic [7:0] ql[$];

  always #5 clk = ~clk;

  uart_word_tx #(.WIDTH(64), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_word(in_word), .transmit(transmit_m), .tx_byte(tx_byte_m),
    .is_transmitting(is_tx), .busy(busy_m), .done(done_m)
  );

  uart_word_tx #(.WIDTH(64), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_word(in_word), .transmit(transmit_l), .tx_byte(tx_byte_l),
    .is_transmitting(is_tx), .busy(busy_l), .done(done_l)
  );

  uart_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(valid_b), .in_ready(in_ready_b),
    .in_word(word_b), .transmit(transmit_b), .tx_byte(tx_byte_b),
    .is_transmitting(is_tx_b), .busy(busy_b), .done(done_b)
  );

  // Uart core stand-in: busy from the cycle after a transmit pulse for 20 cycles.
  always_ff @(posedge clk) begin
    if (transmit_m) uart_cnt <= 20;
    else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    if (transmit_b) uart_cnt_b <= 20;
    else if (uart_cnt_b > 0) uart_cnt_b <= uart_cnt_b - 1;
  end
  assign is_tx   = (uart_cnt != 0) || force_busy;
  assign is_tx_b = (uart_cnt_b != 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: a word becomes eight bytes, ordered by significance.
  function automatic void push_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
      qm.push_back(8'((w >> (8 * (7 - i))) & 64'hFF));
      ql.push_back(8'((w >> (8 * i)) & 64'hFF));
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      if (in_valid && in_ready_m) push_word(in_word);
      if (transmit_m) begin
        pulse_cnt++;
        check("no_tx_while_core_busy", is_tx, 0);
        check("lsb_pulse_aligned", transmit_l, 1);
        if (qm.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          check("byte_msb_first", tx_byte_m, qm.pop_front());
          check("byte_lsb_first", tx_byte_l, ql.pop_front());
        end
      end
      if (done_m) begin
        done_cnt++;
        check("done_all_bytes_sent", qm.size(), 0);
        check("done_busy_low", busy_m, 0);
        check("lsb_done_aligned", done_l, 1);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready_m && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_m) check("timeout_ready", 0, 1);
  endtask

  task automatic send(input logic [63:0] w, input bit chk_lat);
    wait_ready();
    in_valid = 1'b1;
    in_word  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      check("lat_cycle1_no_tx", transmit_m, 0);
      check("lat_cycle1_busy", busy_m, 1);
      @(negedge clk);
      check("lat_cycle2_tx", transmit_m, 1);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done_m && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done_m) check("timeout_done", 0, 1);
  endtask

  initial begin
    int p0, d0, got;
    logic [63:0] w;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_transmit", transmit_m, 0);
    check("rst_tx_byte", tx_byte_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_in_ready", in_ready_m, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready_m, 1);

    // Fixed word plus random words, both byte orders, with latency check
    p0 = pulse_cnt; d0 = done_cnt;
    send(64'h0123456789ABCDEF, 1'b1);
    wait_done();
    @(negedge clk);
    check("after_done_in_ready", in_ready_m, 1);
    check("after_done_busy", busy_m, 0);
    check("word1_pulses", pulse_cnt - p0, 8);
    check("word1_dones", done_cnt - d0, 1);
    for (int k = 0; k < 4; k++) begin
      w = {$urandom, $urandom};
      send(w, 1'b0);
      wait_done();
    end

    // Core busy at accept: no pulse until it falls, then ARM -> PULSE
    force_busy = 1'b1;
    p0 = pulse_cnt;
    send({$urandom, $urandom}, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    check("held_no_pulse", pulse_cnt - p0, 0);
    force_busy = 1'b0;
    @(negedge clk);
    check("fall_no_early_pulse", transmit_m, 0);
    @(negedge clk);
    check("fall_pulse_latency", transmit_m, 1);
    wait_done();

    // in_valid held across two words: second accepted only after done
    p0 = pulse_cnt;
    wait_ready();
    in_valid = 1'b1;
    in_word  = {$urandom, $urandom};
    @(posedge clk); #1;
    in_word  = {$urandom, $urandom};
    wait_done();
    check("fin_not_ready", in_ready_m, 0);
    @(negedge clk);
    check("ready_after_done", in_ready_m, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    check("b2b_pulses", pulse_cnt - p0, 16);

    // Reset after the third pulse of a word
    p0 = pulse_cnt;
    send({$urandom, $urandom}, 1'b0);
    got = 0;
    while (pulse_cnt - p0 < 3 && got < 2000) begin
      @(posedge clk);
      got++;
    end
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy_m, 0);
    check("midrst_tx_byte", tx_byte_m, 0);
    check("midrst_in_ready", in_ready_m, 1);
    p0 = pulse_cnt; d0 = done_cnt;
    repeat (80) @(negedge clk);
    check("midrst_no_pulse", pulse_cnt - p0, 0);
    check("midrst_no_done", done_cnt - d0, 0);
    send({$urandom, $urandom}, 1'b1);
    wait_done();
    check("after_rst_pulses", pulse_cnt - p0, 8);

    // WIDTH=8: exactly one byte per word
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      int n;
      b = 8'($urandom);
      got = 0;
      n = 0;
      valid_b = 1'b1;
      word_b  = b;
      @(posedge clk); #1;
      valid_b = 1'b0;
      @(negedge clk);
      while (!done_b && n < 200) begin
        if (transmit_b) begin
          got++;
          check("w8_byte", tx_byte_b, b);
        end
        @(negedge clk);
        n++;
      end
      check("w8_done_seen", done_b, 1);
      check("w8_pulses", got, 1);
      @(negedge clk);
      check("w8_ready_after", in_ready_b, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
